serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Transmit-side counterpart of the team's serial run-of-ones sequence detector.
- Accepts a parallel word with a start pulse and serialises it onto a 1-bit line as a frame: preamble of PRE_LEN ones, then payload MSB first, then one guard zero.
- Stuffs a 0 after every third consecutive payload 1, so a downstream 4-ones detector fires only on the preamble.
- Sits between a host/control block and the serial link; idle line level is 0.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PRE_LEN, 4, preamble length in ones (>=1); matches the detector run length.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- start  input  1  request to send; sampled only when ready=1.
- data_in  input  DATA_W  payload, captured on the accepted start cycle.
- ready  output  1  1 in IDLE; a start is accepted this cycle.
- busy  output  1  1 while a frame is on the line (PREAMBLE..GUARD).
- cout  output  1  serial data, registered.
- cout_valid  output  1  1 on every cycle cout carries a frame bit, including stuff and guard bits.
- frame_done  output  1  single-cycle pulse on the cycle after the guard bit.

Behaviour:
- All outputs are registered. Synchronous reset, active high.
- Reset values: ready=1, busy=0, cout=0, cout_valid=0, frame_done=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, PREAMBLE, DATA, STUFF, GUARD.
- IDLE:
  - cout=0, cout_valid=0.
  - start=1 captures data_in into the shift register, sets ready=0 and busy=1 at the next edge, and enters PREAMBLE.
- PREAMBLE:
  - Emits PRE_LEN cycles of cout=1, cout_valid=1.
  - The first preamble bit appears on the cycle after start is accepted (latency 1).
  - The ones-run counter is cleared at the PREAMBLE->DATA transition.
- DATA:
  - Emits payload MSB first, one bit per cycle.
  - The ones-run counter increments on each 1 and clears on each 0.
  - When the counter reaches 3, the next cycle is STUFF.
- STUFF:
  - Emits cout=0, cout_valid=1 for one cycle and clears the run counter.
  - Resumes DATA if payload bits remain, else goes to GUARD.
  - A stuff bit is inserted even when the third 1 is the last payload bit.
- GUARD:
  - Emits cout=0, cout_valid=1 for one cycle.
  - Next edge: IDLE, ready=1, busy=0, frame_done=1 for one cycle.
- Frame length: PRE_LEN + DATA_W + floor-stuffs + 1 guard cycles.
- start while ready=0 is ignored and does not queue. data_in is don't-care outside the accepted cycle.
- start on the frame_done cycle is accepted (ready=1 that cycle). The next frame's preamble begins one cycle later, so there are at least 2 line zeros between frames.
- rst mid-frame: at the next edge all outputs go to reset values and the frame is abandoned. No partial-frame completion; frame_done is not pulsed.
- The payload never contains 4 consecutive ones on the line.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of all DATA_W payload bits) is sent after the last payload bit and before GUARD.
  - The parity bit is part of the stuffing run: it counts toward the ones-run and can trigger a stuff after it.
  - Frame length increases by 1 plus any extra stuff bit.
- Undefined: no parity bit; behaviour exactly as above.

Test Plan:
- Reset then data_in=8'h00, start 1 cycle -> next cycle onward cout = 1111 00000000 0 (13 cycles) with cout_valid=1 throughout; frame_done pulses next; ready returns 1.
- data_in=8'hFF -> cout = 1111 1110 1110 11 0 (15 cycles: 4 preamble, 8 data + 2 stuffs, guard); a 4-ones detector on cout fires exactly once, on the 4th cycle.
- data_in=8'h07 -> cout = 1111 00000 111 0 0 (trailing stuff then guard, 14 cycles); busy=1 for all 14.
- start pulsed again mid-frame with data_in=8'hAA -> ignored; the current frame completes unchanged. start on the frame_done cycle with 8'hAA -> preamble starts next cycle, then 10101010 0.
- rst asserted on the 6th frame cycle -> next edge cout=0, cout_valid=0, busy=0, ready=1, no frame_done; a following start of 8'h00 produces a clean 13-cycle frame.
- With SERIAL_FRAME_TX_PARITY_EN, data_in=8'h01 -> cout = 1111 00000001 1 0 (parity=1, 14 cycles); 8'hFF -> 1111 1110 1110 11 0 0 (parity 0, 16 cycles).

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames a word as PRE_LEN ones, MSB-first payload with a 0 stuffed after every third 1, then a guard 0; in: clk, rst, start, data_in; out: ready, busy, cout, cout_valid, frame_done; SERIAL_FRAME_TX_PARITY_EN appends an even-parity bit to the payload
module serial_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              cout,
  output logic              cout_valid,
  output logic              frame_done
);
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int MX = (PRE_LEN > NB) ? PRE_LEN : NB;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, STUFF, GUARD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] run_q, run_d;
  logic [NB-1:0] sh_q, sh_d, load;
  logic cout_q, cout_d, vld_q, vld_d, busy_q, busy_d, ready_q, ready_d, done_q, done_d;
  logic nb, more;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  assign load = {data_in, ^data_in};
`else
  assign load = data_in;
`endif
  assign nb = sh_q[NB-1];
  assign more = cnt_q < CW'(NB);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    run_d = run_q;
    sh_d = sh_q;
    cout_d = 1'b0;
    vld_d = 1'b1;
    busy_d = 1'b1;
    ready_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PREAMBLE;
          cnt_d = CW'(1);
          sh_d = load;
          cout_d = 1'b1;
        end else begin
          vld_d = 1'b0;
          busy_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (cnt_q < CW'(PRE_LEN)) begin
          cnt_d = cnt_q + CW'(1);
          cout_d = 1'b1;
        end else begin
          state_d = DATA;
          cnt_d = CW'(1);
          sh_d = sh_q << 1;
          cout_d = nb;
          run_d = nb ? 2'd1 : 2'd0;
        end
      end
      DATA, STUFF: begin
        if (state_q == DATA && run_q == 2'd3) begin
          state_d = STUFF;
          run_d = 2'd0;
        end else if (more) begin
          state_d = DATA;
          cnt_d = cnt_q + CW'(1);
          sh_d = sh_q << 1;
          cout_d = nb;
          run_d = nb ? run_q + 2'd1 : 2'd0;
        end else begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        state_d = IDLE;
        cnt_d = '0;
        run_d = 2'd0;
        vld_d = 1'b0;
        busy_d = 1'b0;
        ready_d = 1'b1;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      run_q <= 2'd0;
      sh_q <= '0;
      cout_q <= 1'b0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      sh_q <= sh_d;
      cout_q <= cout_d;
      vld_q <= vld_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      done_q <= done_d;
    end
  end
  assign ready = ready_q;
  assign busy = busy_q;
  assign cout = cout_q;
  assign cout_valid = vld_q;
  assign frame_done = done_q;
endmodule
